sha256_round_ctrl: RTL and testbench

- Sequencing FSM for the SHA-256 compression datapath.
- Accepts one 512-bit block per handshake.
- Drives the round-constant ROM with its address and enable, accounting for that ROM's one-cycle registered latency.
- Issues per-round strobes to the message schedule and working-variable logic, then the hash-update and digest handshake.

---
 rtl/sha256_pkg.sv | 27 ++
 rtl/sha256_round_ctrl_if.sv | 43 ++++
 rtl/sha256_round_cnt.sv | 50 +++++
 rtl/sha256_round_ctrl.sv | 150 +++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round controller and its datapath.
// The optional abort input is enabled with SHA256_CTRL_ABORT_EN.
package sha256_pkg;

   localparam int ADDR_WTH   = 6;
   localparam int NUM_ROUNDS = 64;
   localparam int MSG_WORDS  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRIME  = 3'd1,
      ROUND  = 3'd2,
      UPDATE = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Initial hash value; element 0 is H0.
   localparam logic [7:0][31:0] HASH_IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   function automatic logic [31:0] iv_word(input logic [2:0] idx);
      return HASH_IV[idx];
   endfunction

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Handshake and strobe bundle between the round controller and the SHA-256 datapath.
// abort exists only when SHA256_CTRL_ABORT_EN is defined.
interface sha256_round_ctrl_if #(
   parameter int ADDR_WTH = sha256_pkg::ADDR_WTH
);
`ifdef SHA256_CTRL_ABORT_EN
   logic                abort;
`endif
   logic                block_valid;
   logic                block_first;
   logic                block_last;
   logic                block_ready;
   logic                rc_enable;
   logic [ADDR_WTH-1:0] rc_addr;
   logic                round_en;
   logic [ADDR_WTH-1:0] round_idx;
   logic                w_direct;
   logic                init_hash;
   logic                load_vars;
   logic                digest_update;
   logic                digest_valid;
   logic                digest_ready;
   logic                busy;

   modport master (
`ifdef SHA256_CTRL_ABORT_EN
      input  abort,
`endif
      input  block_valid, block_first, block_last, digest_ready,
      output block_ready, rc_enable, rc_addr, round_en, round_idx, w_direct,
      output init_hash, load_vars, digest_update, digest_valid, busy
   );

   modport slave (
`ifdef SHA256_CTRL_ABORT_EN
      output abort,
`endif
      output block_valid, block_first, block_last, digest_ready,
      input  block_ready, rc_enable, rc_addr, round_en, round_idx, w_direct,
      input  init_hash, load_vars, digest_update, digest_valid, busy
   );

endinterface

// File: rtl/sha256_round_cnt.sv
// Round index counter: clear, load and saturating increment with a terminal-count flag.
module sha256_round_cnt #(
   parameter int WTH  = 6,
   parameter int LAST = 63
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clr_i,
   input  logic           inc_i,
   input  logic           load_i,
   input  logic [WTH-1:0] load_val_i,
   output logic [WTH-1:0] cnt_o,
   output logic           tc_o
);

   localparam logic [WTH-1:0] LAST_C = WTH'(LAST);

   logic [WTH-1:0] cnt_q;
   logic [WTH-1:0] cnt_d;
   logic           tc_s;

   assign tc_s = (cnt_q == LAST_C);

   // Next count; increment stops at the terminal value so the index never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && !tc_s) begin
         cnt_d = cnt_q + WTH'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = tc_s;

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencing FSM for the SHA-256 compression datapath: block handshake, K-ROM addressing,
// per-round strobes and digest handshake. SHA256_CTRL_ABORT_EN adds an abort input.
module sha256_round_ctrl #(
   parameter int ADDR_WTH   = sha256_pkg::ADDR_WTH,
   parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS,
   parameter int MSG_WORDS  = sha256_pkg::MSG_WORDS
) (
   input  logic               clk,
   input  logic               reset,
   sha256_round_ctrl_if.master bus
);
   import sha256_pkg::*;

   localparam logic [ADDR_WTH-1:0] MSG_WORDS_C = ADDR_WTH'(MSG_WORDS);

   state_e              state_q, state_d;
   logic                last_q, last_d;
   logic                cnt_clr_s, cnt_inc_s, cnt_tc_s, abort_s;
   logic [ADDR_WTH-1:0] cnt_s;

   logic                block_ready_s, rc_enable_s, round_en_s, w_direct_s;
   logic                init_hash_s, load_vars_s, digest_update_s, digest_valid_s;
   logic [ADDR_WTH-1:0] rc_addr_s, round_idx_s;

`ifdef SHA256_CTRL_ABORT_EN
   assign abort_s = bus.abort;
`else
   assign abort_s = 1'b0;
`endif

   sha256_round_cnt #(
      .WTH  (ADDR_WTH),
      .LAST (NUM_ROUNDS - 1)
   ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (cnt_clr_s),
      .inc_i      (cnt_inc_s),
      .load_i     (1'b0),
      .load_val_i ({ADDR_WTH{1'b0}}),
      .cnt_o      (cnt_s),
      .tc_o       (cnt_tc_s)
   );

   // Next-state and output decode.
   always_comb begin
      state_d         = state_q;
      last_d          = last_q;
      cnt_clr_s       = 1'b0;
      cnt_inc_s       = 1'b0;
      block_ready_s   = 1'b0;
      rc_enable_s     = 1'b0;
      rc_addr_s       = '0;
      round_en_s      = 1'b0;
      round_idx_s     = '0;
      w_direct_s      = 1'b0;
      init_hash_s     = 1'b0;
      load_vars_s     = 1'b0;
      digest_update_s = 1'b0;
      digest_valid_s  = 1'b0;
      case (state_q)
         IDLE: begin
            block_ready_s = 1'b1;
            // No handshake may be taken while reset is held.
            if (bus.block_valid && !reset) begin
               load_vars_s = 1'b1;
               init_hash_s = bus.block_first;
               last_d      = bus.block_last;
               cnt_clr_s   = 1'b1;
               state_d     = PRIME;
            end else begin
               state_d = IDLE;
            end
         end
         PRIME: begin
            if (abort_s) begin
               cnt_clr_s = 1'b1;
               state_d   = IDLE;
            end else begin
               rc_enable_s = 1'b1;
               rc_addr_s   = '0;
               state_d     = ROUND;
            end
         end
         ROUND: begin
            if (abort_s) begin
               cnt_clr_s = 1'b1;
               state_d   = IDLE;
            end else begin
               round_en_s  = 1'b1;
               round_idx_s = cnt_s;
               w_direct_s  = (cnt_s < MSG_WORDS_C);
               // The ROM address runs one round ahead to cover its registered read.
               if (cnt_tc_s) begin
                  cnt_clr_s = 1'b1;
                  state_d   = UPDATE;
               end else begin
                  rc_enable_s = 1'b1;
                  rc_addr_s   = cnt_s + ADDR_WTH'(1);
                  cnt_inc_s   = 1'b1;
               end
            end
         end
         UPDATE: begin
            if (abort_s) begin
               state_d = IDLE;
            end else begin
               digest_update_s = 1'b1;
               state_d         = last_q ? DONE : IDLE;
            end
         end
         DONE: begin
            if (abort_s) begin
               state_d = IDLE;
            end else begin
               digest_valid_s = 1'b1;
               state_d        = bus.digest_ready ? IDLE : DONE;
            end
         end
         default: begin
            cnt_clr_s = 1'b1;
            state_d   = IDLE;
         end
      endcase
   end

   // State and last-block flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   assign bus.block_ready   = block_ready_s;
   assign bus.rc_enable     = rc_enable_s;
   assign bus.rc_addr       = rc_addr_s;
   assign bus.round_en      = round_en_s;
   assign bus.round_idx     = round_idx_s;
   assign bus.w_direct      = w_direct_s;
   assign bus.init_hash     = init_hash_s;
   assign bus.load_vars     = load_vars_s;
   assign bus.digest_update = digest_update_s;
   assign bus.digest_valid  = digest_valid_s;
   assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: per-cycle expectations derived from the handshake offset,
// plus a registered round-constant ROM model.
module tb_sha256_round_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   sha256_round_ctrl_if #(.ADDR_WTH(6)) bus ();

   sha256_round_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] k_tab [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Round-constant ROM with one cycle of registered latency.
   logic [31:0] rom_q;
   always @(posedge clk) if (bus.rc_enable === 1'b1) rom_q <= k_tab[bus.rc_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One block from handshake to its end; on return the FSM is in IDLE ready for a handshake.
   task automatic run_block(input bit first, input bit last, input int rdy_wait, output int hs_cyc);
      logic [5:0] exp_addr;
      bus.block_valid = 1'b1;
      bus.block_first = first;
      bus.block_last  = last;
      #1;
      hs_cyc = cyc;
      total++;
      if (bus.block_ready !== 1'b1 || bus.load_vars !== 1'b1 || bus.init_hash !== first) begin
         bad++;
         $display("FAIL handshake: ready=%b load_vars=%b init_hash=%b, want 1 1 %b",
                  bus.block_ready, bus.load_vars, bus.init_hash, first);
      end
      tick();
      bus.block_valid = 1'b0;
      bus.block_first = 1'($urandom);
      bus.block_last  = 1'($urandom);
      #1;
      total++;
      if (bus.rc_enable !== 1'b1 || bus.rc_addr !== 6'd0 || bus.round_en !== 1'b0 ||
          bus.busy !== 1'b1 || bus.block_ready !== 1'b0 || bus.load_vars !== 1'b0) begin
         bad++;
         $display("FAIL prime: rc_en=%b rc_addr=%0d round_en=%b busy=%b ready=%b, want 1 0 0 1 0",
                  bus.rc_enable, bus.rc_addr, bus.round_en, bus.busy, bus.block_ready);
      end
      tick();
      for (int t = 0; t < 64; t++) begin
         bus.block_valid  = (t == 20) ? 1'b1 : 1'($urandom);
         bus.digest_ready = 1'($urandom);
         #1;
         exp_addr = (t < 63) ? 6'(t + 1) : 6'd0;
         total++;
         if (bus.round_en !== 1'b1 || bus.round_idx !== 6'(t) || bus.w_direct !== (t < 16)) begin
            bad++;
            $display("FAIL round t=%0d: round_en=%b idx=%0d w_direct=%b, want 1 %0d %b",
                     t, bus.round_en, bus.round_idx, bus.w_direct, t, (t < 16));
         end
         total++;
         if (bus.rc_enable !== (t < 63) || bus.rc_addr !== exp_addr) begin
            bad++;
            $display("FAIL rc_lead t=%0d: rc_en=%b rc_addr=%0d, want %b %0d",
                     t, bus.rc_enable, bus.rc_addr, (t < 63), exp_addr);
         end
         total++;
         if (rom_q !== k_tab[t]) begin
            bad++;
            $display("FAIL rom_k t=%0d: got %h want %h", t, rom_q, k_tab[t]);
         end
         total++;
         if (bus.block_ready !== 1'b0 || bus.load_vars !== 1'b0 || bus.init_hash !== 1'b0 ||
             bus.digest_update !== 1'b0 || bus.digest_valid !== 1'b0) begin
            bad++;
            $display("FAIL round_quiet t=%0d: ready=%b load=%b init=%b upd=%b dv=%b, want all 0",
                     t, bus.block_ready, bus.load_vars, bus.init_hash, bus.digest_update, bus.digest_valid);
         end
         tick();
      end
      bus.block_valid  = 1'b0;
      bus.digest_ready = 1'($urandom);
      #1;
      total++;
      if (bus.digest_update !== 1'b1 || bus.round_en !== 1'b0 || bus.rc_enable !== 1'b0 ||
          bus.digest_valid !== 1'b0 || bus.round_idx !== 6'd0) begin
         bad++;
         $display("FAIL update: upd=%b round_en=%b rc_en=%b dv=%b idx=%0d, want 1 0 0 0 0",
                  bus.digest_update, bus.round_en, bus.rc_enable, bus.digest_valid, bus.round_idx);
      end
      tick();
      if (last) begin
         for (int i = 0; i < rdy_wait; i++) begin
            bus.digest_ready = 1'b0;
            bus.block_valid  = 1'($urandom);
            #1;
            total++;
            if (bus.digest_valid !== 1'b1 || bus.block_ready !== 1'b0 || bus.busy !== 1'b1 ||
                bus.load_vars !== 1'b0) begin
               bad++;
               $display("FAIL done_hold %0d: dv=%b ready=%b busy=%b load=%b, want 1 0 1 0",
                        i, bus.digest_valid, bus.block_ready, bus.busy, bus.load_vars);
            end
            tick();
         end
         bus.block_valid  = 1'b0;
         bus.digest_ready = 1'b1;
         #1;
         total++;
         if (bus.digest_valid !== 1'b1) begin
            bad++;
            $display("FAIL done_accept: dv=%b want 1", bus.digest_valid);
         end
         tick();
      end
      bus.block_valid  = 1'b0;
      bus.digest_ready = 1'b0;
      #1;
      total++;
      if (bus.block_ready !== 1'b1 || bus.busy !== 1'b0 || bus.digest_valid !== 1'b0 ||
          bus.digest_update !== 1'b0 || bus.w_direct !== 1'b0) begin
         bad++;
         $display("FAIL back_idle last=%b: ready=%b busy=%b dv=%b upd=%b wd=%b, want 1 0 0 0 0",
                  last, bus.block_ready, bus.busy, bus.digest_valid, bus.digest_update, bus.w_direct);
      end
   endtask

   // Hand off a single-block message and wait until the given round is on the outputs.
   task automatic start_to_round(input int target, output bit found);
      found = 1'b0;
      bus.block_valid = 1'b1;
      bus.block_first = 1'b1;
      bus.block_last  = 1'b1;
      tick();
      bus.block_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (bus.round_en === 1'b1 && bus.round_idx === 6'(target)) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL reach_round: round %0d not seen within 100 cycles", target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.block_valid  = 1'b1;
      bus.block_first  = 1'b1;
      bus.block_last   = 1'b1;
      bus.digest_ready = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
      bus.abort = 1'b0;
`endif
      tick();
      tick();
      total++;
      if (bus.block_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rc_enable !== 1'b0 || bus.round_en !== 1'b0 ||
          bus.load_vars !== 1'b0 || bus.init_hash !== 1'b0 || bus.digest_update !== 1'b0 ||
          bus.digest_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_vals: ready=%b busy=%b rc_en=%b load=%b init=%b upd=%b dv=%b",
                  bus.block_ready, bus.busy, bus.rc_enable, bus.load_vars, bus.init_hash,
                  bus.digest_update, bus.digest_valid);
      end
      bus.block_valid = 1'b0;
      reset = 1'b0;
      tick();
      total++;
      if (bus.busy !== 1'b0 || bus.block_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_no_hs: busy=%b ready=%b, want 0 1", bus.busy, bus.block_ready);
      end
   endtask

   task automatic test_single_block();
      int h;
      run_block(1'b1, 1'b1, 5, h);
   endtask

   task automatic test_back_to_back();
      int h1, h2;
      run_block(1'b1, 1'b0, 0, h1);
      run_block(1'b0, 1'b1, 2, h2);
      total++;
      if (h2 - h1 !== 67) begin
         bad++;
         $display("FAIL throughput: handshake gap %0d want 67", h2 - h1);
      end
   endtask

   task automatic test_reset_mid_round();
      bit found;
      int upd_seen;
      start_to_round(30, found);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.block_ready !== 1'b1 || bus.rc_enable !== 1'b0 ||
          bus.digest_update !== 1'b0 || bus.round_en !== 1'b0 || bus.round_idx !== 6'd0) begin
         bad++;
         $display("FAIL reset_abort: busy=%b ready=%b rc_en=%b upd=%b round_en=%b",
                  bus.busy, bus.block_ready, bus.rc_enable, bus.digest_update, bus.round_en);
      end
      upd_seen = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (bus.digest_update !== 1'b0 || bus.busy !== 1'b0) upd_seen++;
      end
      total++;
      if (upd_seen != 0) begin
         bad++;
         $display("FAIL reset_quiet: %0d active cycles after reset, want 0", upd_seen);
      end
      test_single_block();
   endtask

`ifdef SHA256_CTRL_ABORT_EN
   task automatic test_abort();
      bit found;
      start_to_round(30, found);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.block_ready !== 1'b1 || bus.rc_enable !== 1'b0 ||
          bus.digest_update !== 1'b0) begin
         bad++;
         $display("FAIL abort_round: busy=%b ready=%b rc_en=%b upd=%b, want 0 1 0 0",
                  bus.busy, bus.block_ready, bus.rc_enable, bus.digest_update);
      end
      start_to_round(63, found);
      tick();
      tick();
      #1;
      total++;
      if (bus.digest_valid !== 1'b1) begin
         bad++;
         $display("FAIL abort_pre_done: dv=%b want 1", bus.digest_valid);
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      #1;
      total++;
      if (bus.digest_valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_done: dv=%b busy=%b, want 0 0", bus.digest_valid, bus.busy);
      end
      test_single_block();
   endtask
`endif

   task automatic test_random();
      int nb, w, gap, h;
      for (int m = 0; m < 5; m++) begin
         nb  = $urandom_range(1, 3);
         w   = $urandom_range(0, 4);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            bus.block_valid  = 1'b0;
            bus.digest_ready = 1'($urandom);
            tick();
            total++;
            if (bus.busy !== 1'b0 || bus.digest_valid !== 1'b0) begin
               bad++;
               $display("FAIL idle_gap: busy=%b dv=%b want 0 0", bus.busy, bus.digest_valid);
            end
         end
         #1;
         for (int b = 0; b < nb; b++) begin
            run_block(b == 0, b == nb - 1, w, h);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      #1;
      test_single_block();
      test_back_to_back();
      test_reset_mid_round();
`ifdef SHA256_CTRL_ABORT_EN
      test_abort();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
